// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef logic port_id_t;

    localparam int NUM_PORTS = 2;
    localparam int ERR_RDATA = 0;

endpackage

// File: rtl/dmem_arb_grant.sv
// Combinational grant select between the two requesters.
// DMEM_ARB_RR_EN selects round-robin tie-break; otherwise port 0 always wins a tie.
module dmem_arb_grant
    import dmem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid_i,
`ifdef DMEM_ARB_RR_EN
    input  port_id_t             last_i,
`endif
    output logic [NUM_PORTS-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
`ifdef DMEM_ARB_RR_EN
        // On a tie, favour the port that was not granted last time.
        if (valid_i[0] && valid_i[1]) begin
            if (last_i == 1'b1) gnt_o[0] = 1'b1;
            else                gnt_o[1] = 1'b1;
        end else begin
            gnt_o = valid_i;
        end
`else
        if (valid_i[0])      gnt_o[0] = 1'b1;
        else if (valid_i[1]) gnt_o[1] = 1'b1;
`endif
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port data memory, one transaction in flight.
// Build option DMEM_ARB_RR_EN: round-robin tie-break instead of fixed port-0 priority.
//
// Handshake: a requester holds pN_valid with stable fields until pN_ready pulses (capture
// in that cycle, IDLE only); memory side holds m_req until m_ack (data same cycle) or timeout;
// completion is a single-cycle pN_rvalid with rs_rdata/rs_err.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            p0_valid,
    input  logic            p0_we,
    input  logic [AW-1:0]   p0_addr,
    input  logic [DW-1:0]   p0_wdata,
    input  logic [DW/8-1:0] p0_be,
    output logic            p0_ready,
    output logic            p0_rvalid,
    input  logic            p1_valid,
    input  logic            p1_we,
    input  logic [AW-1:0]   p1_addr,
    input  logic [DW-1:0]   p1_wdata,
    input  logic [DW/8-1:0] p1_be,
    output logic            p1_ready,
    output logic            p1_rvalid,
    output logic [DW-1:0]   rs_rdata,
    output logic            rs_err,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy,
    output logic [1:0]      dbg_state_o
);

    localparam int BW = DW / 8;
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_TERM = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '1;

    arb_state_e           state_q, state_d;
    logic [NUM_PORTS-1:0] valid_vec;
    logic [NUM_PORTS-1:0] gnt;
    logic                 accept;
    logic                 sel1;
    logic                 tmo_hit;

    logic                 we_q;
    logic [AW-1:0]        addr_q;
    logic [DW-1:0]        wdata_q;
    logic [BW-1:0]        be_q;
    port_id_t             port_q;
    logic [CW-1:0]        cnt_q;
    logic [DW-1:0]        rdata_q;
    logic                 err_q;

    assign valid_vec = {p1_valid, p0_valid};

`ifdef DMEM_ARB_RR_EN
    port_id_t last_q;

    dmem_arb_grant u_grant (
        .valid_i (valid_vec),
        .last_i  (last_q),
        .gnt_o   (gnt)
    );

    // Reset value 1 lets port 0 win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    last_q <= 1'b1;
        else if (accept) last_q <= sel1;
    end
`else
    dmem_arb_grant u_grant (
        .valid_i (valid_vec),
        .gnt_o   (gnt)
    );
`endif

    assign accept  = (state_q == IDLE) && (|gnt);
    assign sel1    = gnt[1];
    assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_TERM);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (m_ack || tmo_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            port_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= sel1 ? p1_we    : p0_we;
                addr_q  <= sel1 ? p1_addr  : p0_addr;
                wdata_q <= sel1 ? p1_wdata : p0_wdata;
                be_q    <= sel1 ? p1_be    : p0_be;
                port_q  <= sel1;
                cnt_q   <= '0;
            end else if (state_q == BUSY && !tmo_hit && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // An ack landing on the terminal count still completes normally.
            if (state_q == BUSY && m_ack) begin
                rdata_q <= we_q ? DW'(ERR_RDATA) : m_rdata;
                err_q   <= 1'b0;
            end else if (state_q == BUSY && tmo_hit) begin
                rdata_q <= DW'(ERR_RDATA);
                err_q   <= 1'b1;
            end
        end
    end

    assign p0_ready    = accept && gnt[0];
    assign p1_ready    = accept && gnt[1];
    assign p0_rvalid   = (state_q == RESP) && (port_q == 1'b0);
    assign p1_rvalid   = (state_q == RESP) && (port_q == 1'b1);
    assign rs_rdata    = (state_q == RESP) ? rdata_q : DW'(ERR_RDATA);
    assign rs_err      = (state_q == RESP) && err_q;
    assign m_req       = (state_q == BUSY);
    assign m_we        = we_q;
    assign m_addr      = addr_q;
    assign m_wdata     = wdata_q;
    assign m_be        = be_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule
